data_mem_resp: RTL
==================

Name: data_mem_resp

Overview:
- Memory-side responder for the core's data-RAM initiator port, which drives ce/we/sel/addr/wdata and expects read data plus a stall.
- Accepts one word or sub-word request and splits it into single-byte accesses on an 8-bit external SRAM port.
- Assembles read data and raises a stall request, fed to ctrl, until the access completes.
- Sits between the core top level and the board/simulation byte memory.

Parameters:
ADDR_W, 17, external byte-address width; CPU address bits [ADDR_W-1:0] are used, upper bits ignored

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
ram_ce_i  in  1  CPU request valid; held stable with addr/we/sel/data while stallreq_o=1
ram_we_i  in  1  1 = write, 0 = read
ram_addr_i  in  32  byte address; bits [1:0] ignored, the word is selected by [ADDR_W-1:2]
ram_sel_i  in  4  byte-lane enables, lane k = bits [8k+7:8k], little-endian
ram_data_i  in  32  CPU write data
ram_data_o  out  32  read data to CPU, registered
stallreq_o  out  1  pipeline stall request to ctrl
ext_ce_o  out  1  external byte access strobe
ext_we_o  out  1  external write enable
ext_addr_o  out  ADDR_W  external byte address = {ram_addr_i[ADDR_W-1:2], lane}
ext_wdata_o  out  8  external write byte
ext_rdata_i  in  8  external read byte, valid the cycle after a read strobe

Behaviour:
- Reset (rst=0, async): state=IDLE, ram_data_o=0, lane mask register=0. ext_ce_o, ext_we_o, ext_addr_o and ext_wdata_o are all 0.
- States: IDLE, ISSUE, WAIT, DONE.
- stallreq_o = ram_ce_i & (state != DONE). It is combinational, so the pipeline freezes in the same cycle the request appears.
- IDLE:
  - On ram_ce_i=1, latch we, sel, word address and wdata; clear ram_data_o to 0; go to ISSUE.
  - If sel=0, go straight to DONE instead; no external access is made and the read result is 0.
- ISSUE:
  - Each cycle, service the lowest-numbered pending lane: ext_ce_o=1, ext_we_o=latched we, ext_addr_o lane bits = lane index, ext_wdata_o = that lane of the latched wdata.
  - Clear that lane from the pending mask.
  - For reads, capture ext_rdata_i into the lane issued the previous cycle, if any.
  - After the last pending lane: a write goes to DONE; a read goes to WAIT.
- WAIT (reads only): ext_ce_o=0; capture ext_rdata_i into the last issued lane; go to DONE.
- DONE:
  - stallreq_o=0 and ram_data_o holds the assembled word; the pipeline advances this cycle.
  - Next state is always IDLE.
  - A request still present on ram_ce_i in the following IDLE cycle is a new request.
- Unselected lanes of ram_data_o read 0; no sign/zero extension is done here (the mem stage does it).
- Latency from request cycle to DONE cycle, N = popcount(sel):
  - write: N+1 cycles;
  - read: N+2 cycles;
  - word read: DONE 6 cycles after the request, i.e. stall asserted for 6 cycles.
- ram_ce_i dropping in ISSUE/WAIT aborts the request: ext_ce_o is gated low the same cycle and the next state is IDLE. ram_data_o then holds partial data, which is don't-care.
- Reset asserted mid-operation forces IDLE immediately, including ext_ce_o=0; no partial write completes after reset.
- ext_ce_o is only ever high in ISSUE; at most one byte access per cycle.

Test Plan:
- Reset: drive rst=0 mid word-read -> ram_data_o=0, ext_ce_o=0 and stallreq_o=0 immediately; after rst=1, state is IDLE.
- Word write: addr=0x100, sel=4'b1111, data=0xDEADBEEF -> ext writes EF@0x100, BE@0x101, AD@0x102, DE@0x103 on consecutive cycles; stallreq_o high 5 cycles; DONE in cycle 5.
- Word read of the same location:
  - required: ram_data_o=0xDEADBEEF in DONE, 6 cycles after the request;
  - required: ext_ce_o high exactly 4 cycles.
- Byte write and read: sel=4'b0100, addr=0x102, data=0x00AA0000 -> a single write of AA@0x102. Then read with sel=4'b0100 -> ram_data_o=0x00AA0000 after 3 cycles.
- Half read, non-contiguous lanes:
  - stimulus: sel=4'b1010 over memory 11,22,33,44 at 0x200..0x203;
  - required: accesses 0x201 then 0x203, ram_data_o=0x44002200.
- sel=0 with ce=1 -> no ext_ce_o, DONE next cycle, ram_data_o=0. Then a back-to-back new request held on ram_ce_i is accepted in the following IDLE cycle.

Source files
------------

// File: rtl/data_mem_resp_if.sv
// CPU data-RAM port bundle: request, write data, read data and stall.
// The master modport is the core side; the slave modport is the responder.
interface data_mem_resp_if;
   logic        ram_ce_i;
   logic        ram_we_i;
   logic [31:0] ram_addr_i;
   logic [3:0]  ram_sel_i;
   logic [31:0] ram_data_i;
   logic [31:0] ram_data_o;
   logic        stallreq_o;

   modport master (
      output ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
      input  ram_data_o, stallreq_o
   );

   modport slave (
      input  ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
      output ram_data_o, stallreq_o
   );
endinterface

// File: rtl/data_mem_resp.sv
// Data-RAM responder: splits one word/sub-word CPU request into single-byte
// accesses on an 8-bit SRAM port, assembles read data and stalls the core
// until the access completes.
module data_mem_resp #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   data_mem_resp_if.slave    bus,
   output logic              ext_ce_o,
   output logic              ext_we_o,
   output logic [ADDR_W-1:0] ext_addr_o,
   output logic [7:0]        ext_wdata_o,
   input  logic [7:0]        ext_rdata_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              state, state_nx;
   logic                we_q;
   logic [3:0]          mask_q;
   logic [ADDR_W-3:0]   word_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   logic [1:0]          prev_lane_q;
   logic                prev_vld_q;

   logic [1:0]          lane;
   logic [3:0]          lane_bit;
   logic                last;

   // Address bits outside the external word address are intentionally ignored.
   logic unused_addr;
   assign unused_addr = ^{bus.ram_addr_i[31:ADDR_W], bus.ram_addr_i[1:0]};

   // Pick the lowest-numbered lane still pending.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      lane = 2'd0;
      if (mask_q[0])      lane = 2'd0;
      else if (mask_q[1]) lane = 2'd1;
      else if (mask_q[2]) lane = 2'd2;
      else                lane = 2'd3;
   end

   assign lane_bit = 4'b0001 << lane;
   assign last     = ((mask_q & ~lane_bit) == 4'b0000);

   // Freeze the pipeline while a request is in flight; released in DONE or under reset.
   assign bus.stallreq_o = rst & bus.ram_ce_i & (state != DONE);
   assign bus.ram_data_o = rdata_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next state and external strobe; a dropped request aborts and gates the strobe at once.
   always_comb begin
      state_nx    = state;
      ext_ce_o    = 1'b0;
      ext_we_o    = 1'b0;
      ext_addr_o  = '0;
      ext_wdata_o = 8'h00;
      unique case (state)
         IDLE: begin
            if (bus.ram_ce_i)
               state_nx = (bus.ram_sel_i == 4'b0000) ? DONE : ISSUE;
         end
         ISSUE: begin
            if (!bus.ram_ce_i) begin
               state_nx = IDLE;
            end else begin
               ext_ce_o    = 1'b1;
               ext_we_o    = we_q;
               ext_addr_o  = {word_q, lane};
               ext_wdata_o = wdata_q[{lane, 3'b000} +: 8];
               if (last) state_nx = we_q ? DONE : WAIT;
            end
         end
         WAIT:    state_nx = bus.ram_ce_i ? DONE : IDLE;
         DONE:    state_nx = IDLE;
      endcase
   end

   // Request latch, lane bookkeeping and read-data assembly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q        <= 1'b0;
         mask_q      <= 4'b0000;
         word_q      <= '0;
         wdata_q     <= 32'h0;
         rdata_q     <= 32'h0;
         prev_lane_q <= 2'd0;
         prev_vld_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ram_ce_i) begin
                  we_q       <= bus.ram_we_i;
                  mask_q     <= bus.ram_sel_i;
                  word_q     <= bus.ram_addr_i[ADDR_W-1:2];
                  wdata_q    <= bus.ram_data_i;
                  rdata_q    <= 32'h0;
                  prev_vld_q <= 1'b0;
               end
            end
            ISSUE: begin
               if (bus.ram_ce_i) begin
                  mask_q <= mask_q & ~lane_bit;
                  // Read byte for the lane strobed last cycle arrives now.
                  if (prev_vld_q)
                     rdata_q[{prev_lane_q, 3'b000} +: 8] <= ext_rdata_i;
                  prev_lane_q <= lane;
                  prev_vld_q  <= ~we_q;
               end
            end
            WAIT: begin
               if (bus.ram_ce_i && prev_vld_q)
                  rdata_q[{prev_lane_q, 3'b000} +: 8] <= ext_rdata_i;
               prev_vld_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
